// File: rtl/trace_pkg.sv
// Shared types for the instruction trace buffer: FSM state, instruction
// class and the per-sample trace payload.
package trace_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned CLASS_W = 3;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } trace_state_e;

    typedef enum logic [CLASS_W-1:0] {
        CLS_UNKNOWN = 3'd0,
        CLS_ADD     = 3'd1,
        CLS_SUB     = 3'd2,
        CLS_AND     = 3'd3,
        CLS_ORR     = 3'd4,
        CLS_LDR     = 3'd5,
        CLS_STR     = 3'd6,
        CLS_B       = 3'd7
    } instr_class_e;

    // Sample payload; the cycle stamp and class are prepended by the buffer
    // because the stamp width is a module parameter.
    typedef struct packed {
        logic [FLAGS_W-1:0] flags;
        logic               pcsrc;
        logic               regwrite;
        logic               memwrite;
        logic [DATA_W-1:0]  result;
        logic [DATA_W-1:0]  instr;
        logic [DATA_W-1:0]  pc;
    } trace_entry_t;

endpackage

// File: rtl/instr_trace_buf_if.sv
// Capture/read bus of the instruction trace buffer.
// slave: the buffer itself; master: the CPU sampler, control and consumer side.
interface instr_trace_buf_if
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CYCLE_W = 16
);
    localparam int unsigned ENTRY_W = 134 + CYCLE_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic                trace_valid;
    logic [DATA_W-1:0]   pc_in;
    logic [DATA_W-1:0]   instr_in;
    logic [DATA_W-1:0]   result_in;
    logic                memwrite_in;
    logic                regwrite_in;
    logic                pcsrc_in;
    logic [FLAGS_W-1:0]  flags_in;
    logic                arm;
    logic                stop;
    logic                clear;
    logic                trig_en;
    logic [DATA_W-1:0]   trig_pc;
    logic                mode_wrap;
    logic                rd_valid;
    logic                rd_ready;
    logic [ENTRY_W-1:0]  rd_entry;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic [STATE_W-1:0]  state_out;

    modport master (
        output trace_valid, pc_in, instr_in, result_in,
        output memwrite_in, regwrite_in, pcsrc_in, flags_in,
        output arm, stop, clear, trig_en, trig_pc, mode_wrap, rd_ready,
        input  rd_valid, rd_entry, count, overflow, state_out
    );

    modport slave (
        input  trace_valid, pc_in, instr_in, result_in,
        input  memwrite_in, regwrite_in, pcsrc_in, flags_in,
        input  arm, stop, clear, trig_en, trig_pc, mode_wrap, rd_ready,
        output rd_valid, rd_entry, count, overflow, state_out
    );

endinterface

// File: rtl/instr_classifier.sv
// Combinational instruction-class decoder for trace entries.
// Only compiled when TRACE_CLASSIFY_EN is defined.
`ifdef TRACE_CLASSIFY_EN
module instr_classifier
    import trace_pkg::*;
(
    input  logic [1:0]    i_op,      // instr[27:26]
    input  logic [3:0]    i_cmd,     // instr[24:21]
    input  logic          i_load,    // instr[20]
    output instr_class_e  o_class_c
);

    // Data-processing opcode, load/store direction or branch
    always_comb begin
        o_class_c = CLS_UNKNOWN;
        case (i_op)
            2'b00: begin
                case (i_cmd)
                    4'b0100: o_class_c = CLS_ADD;
                    4'b0010: o_class_c = CLS_SUB;
                    4'b0000: o_class_c = CLS_AND;
                    4'b1100: o_class_c = CLS_ORR;
                    default: o_class_c = CLS_UNKNOWN;
                endcase
            end
            2'b01:   o_class_c = i_load ? CLS_LDR : CLS_STR;
            2'b10:   o_class_c = CLS_B;
            default: o_class_c = CLS_UNKNOWN;
        endcase
    end

endmodule
`endif

// File: rtl/instr_trace_buf.sv
// Instruction trace buffer: arms on a trigger, captures retired-instruction
// samples with a cycle stamp into a circular RAM and drains them through a
// valid/ready read port.
// Optional feature macro: TRACE_CLASSIFY_EN (fills the class field with a
// decoded instruction class; otherwise the class field is constant 0).
module instr_trace_buf
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CYCLE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    instr_trace_buf_if.slave bus
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned PAYLOAD_W = $bits(trace_entry_t);
    localparam int unsigned SLOT_W    = CLASS_W + CYCLE_W + PAYLOAD_W;
    localparam int unsigned ENTRY_W   = 134 + CYCLE_W;
    localparam int unsigned PAD_W     = ENTRY_W - SLOT_W;

    localparam logic [STATE_W-1:0] S_IDLE    = 2'(ST_IDLE);
    localparam logic [STATE_W-1:0] S_ARMED   = 2'(ST_ARMED);
    localparam logic [STATE_W-1:0] S_CAPTURE = 2'(ST_CAPTURE);
    localparam logic [STATE_W-1:0] S_FROZEN  = 2'(ST_FROZEN);

    logic [STATE_W-1:0] r_state;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_rd_valid;
    logic [CYCLE_W-1:0] r_cycle;
    logic [SLOT_W-1:0]  r_mem [DEPTH];

    logic [STATE_W-1:0] w_next_state;
    logic [PTR_W-1:0]   w_next_wr_ptr;
    logic [PTR_W-1:0]   w_next_rd_ptr;
    logic [CNT_W-1:0]   w_next_count;
    logic               w_next_overflow;
    logic               w_trig_hit;
    logic               w_full;
    logic               w_pop;
    logic               w_store_req;
    logic               w_store;
    logic               w_overwrite;
    instr_class_e       w_class;
    trace_entry_t       w_payload;
    logic [SLOT_W-1:0]  w_slot;

`ifdef TRACE_CLASSIFY_EN
    instr_classifier u_classifier (
        .i_op      (bus.instr_in[27:26]),
        .i_cmd     (bus.instr_in[24:21]),
        .i_load    (bus.instr_in[20]),
        .o_class_c (w_class)
    );
`else
    assign w_class = CLS_UNKNOWN;
`endif

    // Pack the current CPU sample into the stored slot image
    always_comb begin
        w_payload          = '0;
        w_payload.flags    = bus.flags_in;
        w_payload.pcsrc    = bus.pcsrc_in;
        w_payload.regwrite = bus.regwrite_in;
        w_payload.memwrite = bus.memwrite_in;
        w_payload.result   = bus.result_in;
        w_payload.instr    = bus.instr_in;
        w_payload.pc       = bus.pc_in;
    end

    assign w_slot     = {w_class, r_cycle, w_payload};
    assign w_trig_hit = bus.trace_valid && (!bus.trig_en || (bus.pc_in == bus.trig_pc));
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_pop      = r_rd_valid && bus.rd_ready;

    // Next state, store/pop decisions and pointer/occupancy updates
    always_comb begin
        w_next_state    = r_state;
        w_next_wr_ptr   = r_wr_ptr;
        w_next_rd_ptr   = r_rd_ptr;
        w_next_count    = r_count;
        w_next_overflow = r_overflow;
        w_store_req     = 1'b0;
        w_store         = 1'b0;
        w_overwrite     = 1'b0;

        if (bus.clear) begin
            w_next_state    = S_IDLE;
            w_next_wr_ptr   = '0;
            w_next_rd_ptr   = '0;
            w_next_count    = '0;
            w_next_overflow = 1'b0;
        end else begin
            // stop outranks arm even where it has no effect itself
            if (bus.stop) begin
                if ((r_state == S_ARMED) || (r_state == S_CAPTURE)) begin
                    w_next_state = S_FROZEN;
                end
            end else begin
                case (r_state)
                    S_IDLE, S_FROZEN: begin
                        if (bus.arm) begin
                            w_next_state = S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (w_trig_hit) begin
                            w_store_req  = 1'b1;
                            w_next_state = S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        w_store_req = bus.trace_valid;
                    end
                    default: begin
                        w_next_state = r_state;
                    end
                endcase
            end

            // A same-cycle pop frees a slot, so a full buffer still accepts
            if (w_store_req) begin
                if (!w_full || w_pop) begin
                    w_store = 1'b1;
                end else if (bus.mode_wrap) begin
                    w_store     = 1'b1;
                    w_overwrite = 1'b1;
                end else begin
                    w_next_state = S_FROZEN;
                end
            end

            if (w_store) begin
                w_next_wr_ptr = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop || w_overwrite) begin
                w_next_rd_ptr = r_rd_ptr + PTR_W'(1);
            end
            if (w_overwrite) begin
                w_next_overflow = 1'b1;
            end
            if (w_store && !w_pop && !w_overwrite) begin
                w_next_count = r_count + CNT_W'(1);
            end else if (w_pop && !w_store) begin
                w_next_count = r_count - CNT_W'(1);
            end
        end
    end

    // State, pointers, occupancy, sticky overflow and free-running cycle stamp
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
            r_cycle    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wr_ptr   <= w_next_wr_ptr;
            r_rd_ptr   <= w_next_rd_ptr;
            r_count    <= w_next_count;
            r_overflow <= w_next_overflow;
            r_rd_valid <= (w_next_count != '0);
            r_cycle    <= r_cycle + CYCLE_W'(1);
        end
    end

    // Trace RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (!reset && w_store) begin
            r_mem[r_wr_ptr] <= w_slot;
        end
    end

    // Read side presents the oldest slot; upper reserved bits read as zero
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_entry  = {{PAD_W{1'b0}}, r_mem[r_rd_ptr]};
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.state_out = r_state;

endmodule

// File: tb/tb_instr_trace_buf.sv
// Bench for instr_trace_buf (DEPTH=4, CYCLE_W=16): directed scenarios with
// literal expectations followed by randomized traffic, all checked every
// cycle against a queue-based model of the buffer.
module tb_instr_trace_buf;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CYCLE_W = 16;
    localparam int unsigned ENTRY_W = 134 + CYCLE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_trace_buf_if #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) bus ();

    instr_trace_buf #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected class field from the instruction-set rules
    function automatic logic [2:0] exp_class(input logic [31:0] ins);
        logic [2:0] c;
        c = 3'd0;
`ifdef TRACE_CLASSIFY_EN
        if (ins[27:26] == 2'b00) begin
            if (ins[24:21] == 4'b0100)      c = 3'd1;
            else if (ins[24:21] == 4'b0010) c = 3'd2;
            else if (ins[24:21] == 4'b0000) c = 3'd3;
            else if (ins[24:21] == 4'b1100) c = 3'd4;
        end else if (ins[27:26] == 2'b01) begin
            c = ins[20] ? 3'd5 : 3'd6;
        end else if (ins[27:26] == 2'b10) begin
            c = 3'd7;
        end
`else
        if (ins == 32'h0) c = 3'd0;
`endif
        return c;
    endfunction

    // ---------------- behavioural model ----------------
    logic [ENTRY_W-1:0] m_q[$];
    int                 m_state = 0;   // 0 idle, 1 armed, 2 capture, 3 frozen
    logic               m_ovf   = 1'b0;
    logic [15:0]        m_cycle = 16'd0;
    bit                 m_live  = 1'b0;
    bit                 m_pop;
    bit                 m_req;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_state = 0;
            m_ovf   = 1'b0;
            m_cycle = 16'd0;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_pop = (m_q.size() != 0) && bus.rd_ready;
            m_req = 1'b0;
            if (bus.clear) begin
                m_q.delete();
                m_ovf   = 1'b0;
                m_state = 0;
            end else begin
                if (bus.stop) begin
                    if (m_state == 1 || m_state == 2) m_state = 3;
                end else if (bus.arm && (m_state == 0 || m_state == 3)) begin
                    m_state = 1;
                end else if (m_state == 1 && bus.trace_valid &&
                             (!bus.trig_en || bus.pc_in == bus.trig_pc)) begin
                    m_req   = 1'b1;
                    m_state = 2;
                end else if (m_state == 2 && bus.trace_valid) begin
                    m_req = 1'b1;
                end
                if (m_pop) void'(m_q.pop_front());
                if (m_req) begin
                    if (m_q.size() >= DEPTH && !bus.mode_wrap) begin
                        m_state = 3;
                    end else begin
                        if (m_q.size() >= DEPTH) begin
                            void'(m_q.pop_front());
                            m_ovf = 1'b1;
                        end
                        m_q.push_back({28'd0, exp_class(bus.instr_in), m_cycle,
                                       bus.flags_in, bus.pcsrc_in, bus.regwrite_in,
                                       bus.memwrite_in, bus.result_in, bus.instr_in,
                                       bus.pc_in});
                    end
                end
            end
            m_cycle = m_cycle + 16'd1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("state_out", bus.state_out, m_state);
            chk("count", bus.count, m_q.size());
            chk("rd_valid", bus.rd_valid, m_q.size() != 0);
            chk("overflow", bus.overflow, m_ovf);
            if (m_q.size() != 0) chk("rd_entry", bus.rd_entry, m_q[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.trace_valid = 1'b0;
        bus.arm         = 1'b0;
        bus.stop        = 1'b0;
        bus.clear       = 1'b0;
        bus.rd_ready    = 1'b0;
    endtask

    task automatic sample(input logic [31:0] pc, input logic [31:0] ins);
        bus.trace_valid = 1'b1;
        bus.pc_in       = pc;
        bus.instr_in    = ins;
        bus.result_in   = $urandom;
        bus.flags_in    = 4'($urandom);
        bus.memwrite_in = 1'($urandom);
        bus.regwrite_in = 1'($urandom);
        bus.pcsrc_in    = 1'($urandom);
    endtask

    task automatic pulse_clear();
        quiet();
        bus.clear = 1'b1;
        tick();
        quiet();
    endtask

    task automatic pulse_arm();
        quiet();
        bus.arm = 1'b1;
        tick();
        quiet();
    endtask

    initial begin
        quiet();
        bus.pc_in = '0; bus.instr_in = '0; bus.result_in = '0;
        bus.flags_in = '0; bus.memwrite_in = 1'b0; bus.regwrite_in = 1'b0;
        bus.pcsrc_in = 1'b0; bus.trig_en = 1'b0; bus.trig_pc = '0;
        bus.mode_wrap = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_state", bus.state_out, 2'd0);
        chk("reset_count", bus.count, 3'd0);
        chk("reset_rd_valid", bus.rd_valid, 1'b0);
        chk("reset_overflow", bus.overflow, 1'b0);

        // PC trigger
        bus.trig_en = 1'b1; bus.trig_pc = 32'h8; bus.mode_wrap = 1'b1;
        pulse_arm();
        chk("trig_armed", bus.state_out, 2'd1);
        sample(32'h0, 32'hE0811002); tick();
        sample(32'h4, 32'hE0811002); tick();
        chk("trig_still_armed", bus.state_out, 2'd1);
        chk("trig_none_stored", bus.count, 3'd0);
        sample(32'h8, 32'hE0811002); tick();
        chk("trig_capture", bus.state_out, 2'd2);
        sample(32'hC, 32'hE0811002); tick();
        chk("trig_count2", bus.count, 3'd2);
        quiet();
        chk("trig_first_pc", bus.rd_entry[31:0], 32'h8);
        bus.rd_ready = 1'b1; tick(); tick();
        chk("trig_drained", bus.count, 3'd0);
        pulse_clear();

        // Wrap mode overwrite
        bus.trig_en = 1'b0; bus.mode_wrap = 1'b1;
        pulse_arm();
        for (int i = 0; i < 6; i++) begin
            sample(32'(i * 4), 32'hE2411001); tick();
        end
        chk("wrap_count", bus.count, 3'd4);
        chk("wrap_overflow", bus.overflow, 1'b1);
        sample(32'h99, 32'hE2411001); bus.stop = 1'b1; tick(); quiet();
        chk("stop_frozen", bus.state_out, 2'd3);
        chk("stop_not_stored", bus.count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_pop_pc", bus.rd_entry[31:0], 32'(8 + i * 4));
            bus.rd_ready = 1'b1; tick(); quiet();
        end
        chk("wrap_empty", bus.rd_valid, 1'b0);
        pulse_clear();

        // Freeze mode
        bus.mode_wrap = 1'b0;
        pulse_arm();
        for (int i = 0; i < 5; i++) begin
            sample(32'(32'h100 + i * 4), 32'hE5812000); tick();
        end
        quiet();
        chk("freeze_state", bus.state_out, 2'd3);
        chk("freeze_count", bus.count, 3'd4);
        chk("freeze_overflow", bus.overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("freeze_pop_pc", bus.rd_entry[31:0], 32'(32'h100 + i * 4));
            bus.rd_ready = 1'b1; tick(); quiet();
        end
        chk("freeze_fifth_absent", bus.count, 3'd0);
        pulse_clear();

        // Full buffer, store and pop together
        bus.mode_wrap = 1'b1;
        pulse_arm();
        for (int i = 0; i < 4; i++) begin
            sample(32'(32'h200 + i * 4), 32'hE1811002); tick();
        end
        chk("full_head", bus.rd_entry[31:0], 32'h200);
        sample(32'h210, 32'hE1811002); bus.rd_ready = 1'b1; tick(); quiet();
        chk("full_pushpop_count", bus.count, 3'd4);
        chk("full_pushpop_ovf", bus.overflow, 1'b0);
        chk("full_pushpop_head", bus.rd_entry[31:0], 32'h204);
        pulse_clear();

        // Reset mid-capture
        pulse_arm();
        for (int i = 0; i < 3; i++) begin
            sample(32'(32'h300 + i * 4), 32'hEA000004); tick();
        end
        chk("pre_reset_count", bus.count, 3'd3);
        sample(32'h30C, 32'hEA000004); bus.rd_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; quiet();
        chk("rst_count", bus.count, 3'd0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_state", bus.state_out, 2'd0);

        // Class field of an LDR
        bus.trig_en = 1'b0;
        pulse_arm();
        sample(32'h400, 32'hE5912000); tick(); quiet();
`ifdef TRACE_CLASSIFY_EN
        chk("class_ldr", bus.rd_entry[121:119], 3'd5);
`else
        chk("class_ldr", bus.rd_entry[121:119], 3'd0);
`endif
        pulse_clear();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) bus.mode_wrap = 1'($urandom);
            if (n % 100 == 0) begin
                bus.trig_en = 1'($urandom);
                bus.trig_pc = 32'($urandom_range(0, 7) * 4);
            end
            case ($urandom_range(0, 7))
                0: sample(32'($urandom_range(0, 7) * 4), 32'hE5912000);
                1: sample(32'($urandom_range(0, 7) * 4), 32'hE0811002);
                default: sample(32'($urandom_range(0, 7) * 4), $urandom);
            endcase
            bus.trace_valid = ($urandom_range(0, 9) < 7);
            bus.arm         = ($urandom_range(0, 99) < 6);
            bus.stop        = ($urandom_range(0, 99) < 3);
            bus.clear       = ($urandom_range(0, 199) < 2);
            bus.rd_ready    = ($urandom_range(0, 9) < 4);
            rst             = ($urandom_range(0, 499) == 0);
            tick();
        end
        quiet();
        rst = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
